pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard and flush controller for the in-order pipeline, generalising the single-bit branch flush into per-stage flush/bubble control. It detects load-use hazards, holds fetch/decode for a configurable number of cycles, and squashes a configurable number of younger stages on a taken branch. It also covers a multi-cycle fetch redirect, tracks a valid bit per pipeline register and keeps saturating stall/flush event counters. It sits beside the datapath and drives the enable/clear pins of every pipeline register.

## Interface
- NUM_STAGES, 4: pipeline registers controlled; index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB, and so on.
- REG_W, 5: register-address width.
- FLUSH_STAGES, 2: youngest registers (indices 0..FLUSH_STAGES-1) cleared on a taken branch; range 1..NUM_STAGES-1.
- LOAD_LAT, 1: stall cycles per load-use hazard; range 1..15.
- REDIRECT_CYC, 1: extra fetch-bubble cycles after a taken branch; range 0..15.
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- fetch_valid  in  1  fetch stage presents an instruction this cycle.
- branch_taken  in  1  the branch in ID/EX resolved taken (qualified internally by stage_valid[1]).
- id_rs1, id_rs2  in  REG_W  decode source registers.
- id_use_rs1, id_use_rs2  in  1  decode actually reads rs1/rs2.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_rd  in  REG_W  ID/EX destination register.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID.
- flush  out  NUM_STAGES  clear pipeline register i next edge.
- stage_valid  out  NUM_STAGES  valid bit of pipeline register i.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- FSM states: RUN, STALL, REDIRECT. A 4-bit down-counter `cnt` is used in STALL and REDIRECT.
- **Branch event (taken):** br = branch_taken & stage_valid[1], accepted in any state.
  - flush[FLUSH_STAGES-1:0] = all ones in that cycle (combinational). Stalls are not asserted.
  - Next state: REDIRECT with cnt = REDIRECT_CYC if REDIRECT_CYC > 0, otherwise RUN.
- **Load-use hazard:** hz = stage_valid[0] & stage_valid[1] & ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)). It is evaluated in RUN only.
  - If br is also asserted, br wins and hz is ignored.
  - When hz is accepted: stall_if = stall_id = 1 and flush[1] = 1 (bubble into ID/EX).
  - If LOAD_LAT > 1: go to STALL with cnt = LOAD_LAT-1.
- **STALL:**
  - Outputs: stall_if, stall_id and flush[1] asserted.
  - cnt decrements each cycle; go to RUN when cnt == 1.
  - Total stall length is exactly LOAD_LAT cycles.
- **REDIRECT:**
  - Outputs: flush[0] asserted (fetched slot discarded), no stalls.
  - cnt decrements each cycle; go to RUN when cnt == 1.
  - A br in REDIRECT re-flushes and reloads cnt.
- **stage_valid update** (registered, every edge, out of reset):
  - Register 0: the update rule for each register is as follows:
    - if flush[0], it becomes 0;
    - else if stall_id, it holds;
    - else it becomes fetch_valid.
  - Register i ≥ 1: the update rule for each register is as follows:
    - if flush[i], it becomes 0;
    - else it becomes stage_valid[i-1].
    - During a stall, flush[1] is set, so register 1 becomes 0.
- **Counters:**
  - stall_cnt increments once per cycle in which stall_if = 1.
  - flush_cnt increments once per accepted br.
  - Both saturate at 2^CNT_W-1.

## Timing
- Reset values:
  - state = RUN, cnt = 0.
  - stage_valid = 0, stall_cnt = flush_cnt = 0.
  - While reset is high: stall_if = stall_id = 0 and flush = all ones.
- A reset asserted mid-STALL or mid-REDIRECT aborts the sequence on the next edge.
- All hazard/branch decisions appear combinationally in the cycle their inputs are present. Zero latency from br or hz to flush/stall.
- State, cnt, stage_valid and counters update on the rising clk edge. This gives 1-cycle visibility of new valid bits.
- Stall-cycle timing:
  - The first stall cycle is the hz detection cycle.
  - Subsequent LOAD_LAT-1 cycles come from the STALL state.
  - stall_if deasserts in cycle LOAD_LAT+1 counting the detection cycle as cycle 1.
- A redirect occupies 1 + REDIRECT_CYC cycles of flush[0].
- The ex_rd == 0 comparison never stalls.

## Test plan
- **Reset:** hold reset 3 cycles with fetch_valid=1. Required: flush = all ones and stage_valid = 0 throughout; after release, stage_valid = 0001, 0011, 0111, 1111 on successive edges.
- **Load-use, LOAD_LAT=1:** stage_valid=1111, ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1. Required: one cycle of stall_if=stall_id=flush[1]=1; the next edge has stage_valid[1]=0 and stage_valid[0]=1; stall_cnt=1.
- **Load-use, LOAD_LAT=3:** same hazard. Required: exactly 3 stall cycles and stall_cnt=3; ex_rd=0 with the same rs gives no stall.
- **Taken branch, FLUSH_STAGES=2, REDIRECT_CYC=2:** stage_valid=1111, then a one-cycle branch_taken. Required: flush=0011 in the branch cycle and flush=0001 for the next 2 cycles; flush_cnt=1; return to RUN.
- **Branch vs. hazard, same cycle:** assert br and hz together. Required: no stall, flush=0011, stall_cnt unchanged.
- **Mid-sequence reset and saturation:**
  - Reset mid-STALL (LOAD_LAT=3, reset in the 2nd stall cycle). Required: stall_if=0 from the reset cycle onward and state RUN after release.
  - Saturation with CNT_W=2 and 5 branches. Required: flush_cnt=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Datapath <-> hazard controller bundle (hazard inputs, stall,
//               flush, valid and counter outputs).
// Revision    : 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int NUM_STAGES = 4,
    parameter int REG_W      = 5,
    parameter int CNT_W      = 16
);
    logic                  fetch_valid;
    logic                  branch_taken;
    logic [REG_W-1:0]      id_rs1;
    logic [REG_W-1:0]      id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  ex_mem_read;
    logic [REG_W-1:0]      ex_rd;
    logic                  stall_if;
    logic                  stall_id;
    logic [NUM_STAGES-1:0] flush;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    // Datapath side
    modport master (
        output fetch_valid, branch_taken, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_mem_read, ex_rd,
        input  stall_if, stall_id, flush, stage_valid, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  fetch_valid, branch_taken, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_mem_read, ex_rd,
        output stall_if, stall_id, flush, stage_valid, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Load-use stall, taken-branch flush/redirect, per-register valid
//               tracking and saturating stall/flush event counters.
// Revision    : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES   = 4,
    parameter int REG_W        = 5,
    parameter int FLUSH_STAGES = 2,
    parameter int LOAD_LAT     = 1,
    parameter int REDIRECT_CYC = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_STALL    = 2'd1;
    localparam logic [1:0] c_ST_REDIRECT = 2'd2;

    typedef enum logic [1:0] {
        S_RUN      = c_ST_RUN,
        S_STALL    = c_ST_STALL,
        S_REDIRECT = c_ST_REDIRECT
    } state_t;

    localparam logic [3:0]            c_STALL_LOAD = 4'(LOAD_LAT - 1);
    localparam logic [3:0]            c_REDIR_LOAD = 4'(REDIRECT_CYC);
    localparam logic [NUM_STAGES-1:0] c_BR_MASK    =
        {{(NUM_STAGES - FLUSH_STAGES){1'b0}}, {FLUSH_STAGES{1'b1}}};
    localparam logic [NUM_STAGES-1:0] c_BUBBLE     = NUM_STAGES'(2);
    localparam logic [NUM_STAGES-1:0] c_FETCH_KILL = NUM_STAGES'(1);
    localparam logic [CNT_W-1:0]      c_CNT_ONE    = CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_br;
    logic                  w_hz;
    logic                  w_stall;
    logic [NUM_STAGES-1:0] w_flush;
    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_STAGES-1:0] w_valid_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    // A branch only counts when ID/EX really holds an instruction.
    assign w_br = bus.branch_taken & r_valid[1];
    assign w_hz = r_valid[0] & r_valid[1] & bus.ex_mem_read & (bus.ex_rd != '0) &
                  ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                   (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_flush     = '0;
        if (reset) begin
            w_flush     = '1;
            w_state_nxt = S_RUN;
            w_cnt_nxt   = 4'd0;
        end else if (w_br) begin
            w_flush = c_BR_MASK;
            if (REDIRECT_CYC > 0) begin
                w_state_nxt = S_REDIRECT;
                w_cnt_nxt   = c_REDIR_LOAD;
            end else begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 4'd0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_hz) begin
                        w_stall = 1'b1;
                        w_flush = c_BUBBLE;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = S_STALL;
                            w_cnt_nxt   = c_STALL_LOAD;
                        end
                    end
                end
                S_STALL: begin
                    w_stall   = 1'b1;
                    w_flush   = c_BUBBLE;
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_REDIRECT: begin
                    w_flush   = c_FETCH_KILL;
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // IF/ID holds under stall; every older register just follows its predecessor.
    assign w_valid_nxt[0] = w_flush[0] ? 1'b0 : (w_stall ? r_valid[0] : bus.fetch_valid);

    generate
        for (genvar i = 1; i < NUM_STAGES; i++) begin : g_valid
            assign w_valid_nxt[i] = w_flush[i] ? 1'b0 : r_valid[i-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_br && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.stall_if    = w_stall;
    assign bus.stall_id    = w_stall;
    assign bus.flush       = w_flush;
    assign bus.stage_valid = r_valid;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Two differently parameterised controllers driven in lockstep
//               and compared against a cycle-level behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_valid, branch_taken, id_use_rs1, id_use_rs2, ex_mem_read;
    logic [4:0] id_rs1, id_rs2, ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // dut0: LOAD_LAT=1 REDIRECT_CYC=2 FLUSH_STAGES=2 CNT_W=16
    // dut1: LOAD_LAT=3 REDIRECT_CYC=1 FLUSH_STAGES=3 CNT_W=2
    pipeline_hazard_ctrl_if #(.NUM_STAGES(4), .REG_W(5), .CNT_W(16)) bus0 ();
    pipeline_hazard_ctrl_if #(.NUM_STAGES(4), .REG_W(5), .CNT_W(2))  bus1 ();

    assign bus0.fetch_valid  = fetch_valid;
    assign bus0.branch_taken = branch_taken;
    assign bus0.id_rs1       = id_rs1;
    assign bus0.id_rs2       = id_rs2;
    assign bus0.id_use_rs1   = id_use_rs1;
    assign bus0.id_use_rs2   = id_use_rs2;
    assign bus0.ex_mem_read  = ex_mem_read;
    assign bus0.ex_rd        = ex_rd;
    assign bus1.fetch_valid  = fetch_valid;
    assign bus1.branch_taken = branch_taken;
    assign bus1.id_rs1       = id_rs1;
    assign bus1.id_rs2       = id_rs2;
    assign bus1.id_use_rs1   = id_use_rs1;
    assign bus1.id_use_rs2   = id_use_rs2;
    assign bus1.ex_mem_read  = ex_mem_read;
    assign bus1.ex_rd        = ex_rd;

    pipeline_hazard_ctrl #(
        .NUM_STAGES(4), .REG_W(5), .FLUSH_STAGES(2), .LOAD_LAT(1), .REDIRECT_CYC(2), .CNT_W(16)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    pipeline_hazard_ctrl #(
        .NUM_STAGES(4), .REG_W(5), .FLUSH_STAGES(3), .LOAD_LAT(3), .REDIRECT_CYC(1), .CNT_W(2)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Reference model: remaining stall / redirect cycles as plain integers.
    int c_ll[2]   = '{1, 3};
    int c_rc[2]   = '{2, 1};
    int c_fs[2]   = '{2, 3};
    int c_cmax[2] = '{65535, 3};

    int         m_stall_rem[2];
    int         m_redir_rem[2];
    logic [3:0] m_sv[2];
    int         m_scnt[2];
    int         m_fcnt[2];

    logic       e_stall[2];
    logic [3:0] e_flush[2];
    logic       e_br[2];
    logic       e_hz[2];

    task automatic model_reset_all();
        for (int k = 0; k < 2; k++) begin
            m_stall_rem[k] = 0;
            m_redir_rem[k] = 0;
            m_sv[k]        = 4'b0000;
            m_scnt[k]      = 0;
            m_fcnt[k]      = 0;
        end
    endtask

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            e_br[k] = branch_taken & m_sv[k][1];
            e_hz[k] = m_sv[k][0] & m_sv[k][1] & ex_mem_read & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
            e_stall[k] = 1'b0;
            e_flush[k] = 4'b0000;
            if (reset) begin
                e_flush[k] = 4'b1111;
            end else if (e_br[k]) begin
                e_flush[k] = 4'((1 << c_fs[k]) - 1);
            end else if (m_stall_rem[k] > 0) begin
                e_stall[k] = 1'b1;
                e_flush[k] = 4'b0010;
            end else if (m_redir_rem[k] > 0) begin
                e_flush[k] = 4'b0001;
            end else if (e_hz[k]) begin
                e_stall[k] = 1'b1;
                e_flush[k] = 4'b0010;
            end
        end
    endtask

    task automatic model_advance();
        logic [3:0] nsv;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_stall_rem[k] = 0;
                m_redir_rem[k] = 0;
                m_sv[k]        = 4'b0000;
                m_scnt[k]      = 0;
                m_fcnt[k]      = 0;
            end else begin
                nsv[0] = e_flush[k][0] ? 1'b0 : (e_stall[k] ? m_sv[k][0] : fetch_valid);
                for (int i = 1; i < 4; i++) begin
                    nsv[i] = e_flush[k][i] ? 1'b0 : m_sv[k][i-1];
                end
                m_sv[k] = nsv;
                if (e_stall[k] && m_scnt[k] < c_cmax[k]) m_scnt[k]++;
                if (e_br[k] && m_fcnt[k] < c_cmax[k]) m_fcnt[k]++;
                if (e_br[k]) begin
                    m_redir_rem[k] = c_rc[k];
                    m_stall_rem[k] = 0;
                end else if (m_stall_rem[k] > 0) begin
                    m_stall_rem[k]--;
                end else if (m_redir_rem[k] > 0) begin
                    m_redir_rem[k]--;
                end else if (e_hz[k]) begin
                    m_stall_rem[k] = c_ll[k] - 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h @%0t", tag, k, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("stall_if",    0, 32'(bus0.stall_if),    32'(e_stall[0]));
        chk("stall_id",    0, 32'(bus0.stall_id),    32'(e_stall[0]));
        chk("flush",       0, 32'(bus0.flush),       32'(e_flush[0]));
        chk("stage_valid", 0, 32'(bus0.stage_valid), 32'(m_sv[0]));
        chk("stall_cnt",   0, 32'(bus0.stall_cnt),   32'(m_scnt[0]));
        chk("flush_cnt",   0, 32'(bus0.flush_cnt),   32'(m_fcnt[0]));
        chk("stall_if",    1, 32'(bus1.stall_if),    32'(e_stall[1]));
        chk("stall_id",    1, 32'(bus1.stall_id),    32'(e_stall[1]));
        chk("flush",       1, 32'(bus1.flush),       32'(e_flush[1]));
        chk("stage_valid", 1, 32'(bus1.stage_valid), 32'(m_sv[1]));
        chk("stall_cnt",   1, 32'(bus1.stall_cnt),   32'(m_scnt[1]));
        chk("flush_cnt",   1, 32'(bus1.flush_cnt),   32'(m_fcnt[1]));
    endtask

    // Inputs are set at posedge+1; outputs are sampled 1 time unit later.
    task automatic step();
        #1;
        model_eval();
        check_all();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle(input int n);
        reset = 1'b0; fetch_valid = 1'b1; branch_taken = 1'b0;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd7;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_use(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1'b1;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b1; branch_taken = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0;
        model_reset_all();
        @(posedge clk);
        #1;

        // Reset held three cycles with fetch_valid high, then valid bits fill in
        for (int i = 0; i < 3; i++) step();
        idle(4);
        chk("fill_sv", 0, 32'(bus0.stage_valid), 32'h0000000f);

        // Load-use hazard
        load_use(5'd5); step();
        idle(5);
        chk("ll1_stall_cnt", 0, 32'(bus0.stall_cnt), 32'd1);
        chk("ll3_stall_cnt", 1, 32'(bus1.stall_cnt), 32'd3);

        // Destination x0 never stalls
        load_use(5'd0); step(); step();
        idle(3);

        // Taken branch with redirect
        branch_taken = 1'b1; step();
        idle(6);

        // Branch and hazard in the same cycle
        load_use(5'd9); branch_taken = 1'b1; step();
        idle(6);

        // Reset in the second stall cycle of the LOAD_LAT=3 controller
        load_use(5'd4); step();
        reset = 1'b1; step();
        idle(5);

        // Repeated branches saturate the narrow counter
        for (int b = 0; b < 5; b++) begin
            branch_taken = 1'b1; step();
            idle(6);
        end
        chk("sat_flush_cnt", 1, 32'(bus1.flush_cnt), 32'd3);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            reset        = ($urandom_range(0, 63) == 0);
            fetch_valid  = ($urandom_range(0, 7) != 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_rd        = 5'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
